// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//
// Run controller for a loadable up/down counter. It moves the counter through
// IDLE, RUN, PAUSE and DONE. A prescaler sets how many clocks pass per count
// step. When a step lands on the terminal value, the controller either
// reloads and keeps running (auto-reload) or stops in DONE (one-shot).
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rstn         synchronous reset, active-high (the name is historical)
//   start        launch from IDLE/DONE, resume from PAUSE (level-sampled)
//   stop         pause request, acted on only in RUN
//   clear        abort to IDLE with the count cleared, in any state
//   load         load load_val into the count (IDLE/PAUSE/DONE)
//   load_val     load value, also the value used for auto-reload
//   term_val     terminal count value, latched at launch
//   dir          0 = count up, 1 = count down, latched at launch
//   auto_reload  1 = reload at terminal and keep running, latched at launch
//   count        current count
//   busy         registered, high in RUN or PAUSE
//   done         registered one-clock pulse per terminal-count event
// -----------------------------------------------------------------------------
module counter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             dir,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  // The prescaler needs at least one bit, even when PRESCALE is 1 and it never
  // leaves zero.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_term;
  logic             r_dir;
  logic             r_auto;
  logic             r_busy;
  logic             r_done;

  logic             w_step_due;
  logic             w_at_term;

  // Step wrap-around is plain modulo 2^WIDTH arithmetic.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                  input logic             down);
    step_count = down ? (c - WIDTH'(1)) : (c + WIDTH'(1));
  endfunction

  // A step is due on the last clock of each prescale period. With PRESCALE=1
  // the prescaler stays at zero, so every RUN clock is a step.
  assign w_step_due = (r_pre == PW'(PRESCALE - 1));
  assign w_at_term  = (r_count == r_term);

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_pre   <= '0;
      r_term  <= '0;
      r_dir   <= 1'b0;
      r_auto  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // done is a single-clock pulse. It is set again only by a terminal event.
      r_done <= 1'b0;

      if (clear) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_pre   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (load) begin
              r_count <= load_val;
            end
            if (start) begin
              r_state <= S_RUN;
              r_pre   <= '0;
              r_busy  <= 1'b1;
              r_term  <= term_val;
              r_dir   <= dir;
              r_auto  <= auto_reload;
            end
          end

          S_RUN: begin
            if (stop) begin
              // The pause wins over any step due this clock. The prescaler
              // freezes so that resume continues the same period.
              r_state <= S_PAUSE;
            end else if (w_step_due) begin
              r_pre <= '0;
              if (w_at_term) begin
                r_done <= 1'b1;
                if (r_auto) begin
                  r_count <= load_val;
                end else begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_count <= step_count(r_count, r_dir);
              end
            end else begin
              r_pre <= r_pre + PW'(1);
            end
          end

          S_PAUSE: begin
            if (load) begin
              r_count <= load_val;
            end
            // Resume keeps the prescaler value and the latched config.
            if (start) begin
              r_state <= S_RUN;
            end
          end

          S_DONE: begin
            if (start) begin
              r_state <= S_RUN;
              r_count <= load_val;
              r_pre   <= '0;
              r_busy  <= 1'b1;
              r_term  <= term_val;
              r_dir   <= dir;
              r_auto  <= auto_reload;
            end else if (load) begin
              r_count <= load_val;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
//
// Two counter_ctrl instances run side by side from shared inputs. One uses
// PRESCALE=1 and the other PRESCALE=3. A behavioural model of each instance
// is compared on every falling edge. Directed phases also pin hand-computed
// values shortly after each rising edge.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;

  localparam int W = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_PAUSE = 2;
  localparam int PH_DONE  = 3;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic         stop;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] term_val;
  logic         dir;
  logic         auto_reload;

  logic [W-1:0] count1;
  logic         busy1;
  logic         done1;
  logic [W-1:0] count3;
  logic         busy3;
  logic         done3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ph;
    int cnt;
    int pre;
    int dir;
    int term;
    int ar;
    int dn;
    int valid;
  } mdl_t;

  mdl_t m1 = '{default: 0};
  mdl_t m3 = '{default: 0};

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(W), .PRESCALE(1)) u1 (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .term_val(term_val), .dir(dir),
    .auto_reload(auto_reload), .count(count1), .busy(busy1), .done(done1)
  );

  counter_ctrl #(.WIDTH(W), .PRESCALE(3)) u3 (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .term_val(term_val), .dir(dir),
    .auto_reload(auto_reload), .count(count3), .busy(busy3), .done(done3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Next model state from the current one and the inputs seen at the edge.
  function automatic mdl_t mstep(input mdl_t m, input int ps,
                                 input int rst, input int clr, input int stp,
                                 input int ld, input int st, input int lv,
                                 input int tv, input int dr, input int ar);
    mdl_t n;
    int   modv;
    n    = m;
    modv = 1 << W;
    n.dn = 0;
    if (rst != 0) begin
      n = '{default: 0};
      n.valid = 1;
      return n;
    end
    if (clr != 0) begin
      n.ph  = PH_IDLE;
      n.cnt = 0;
      n.pre = 0;
      return n;
    end
    if (m.ph == PH_IDLE) begin
      if (ld != 0) n.cnt = lv;
      if (st != 0) begin
        n.ph = PH_RUN; n.pre = 0; n.dir = dr; n.term = tv; n.ar = ar;
      end
    end else if (m.ph == PH_RUN) begin
      if (stp != 0) begin
        n.ph = PH_PAUSE;
      end else if (m.pre == ps - 1) begin
        n.pre = 0;
        if (m.cnt == m.term) begin
          n.dn = 1;
          if (m.ar != 0) n.cnt = lv;
          else n.ph = PH_DONE;
        end else begin
          n.cnt = (m.cnt + ((m.dir != 0) ? modv - 1 : 1)) % modv;
        end
      end else begin
        n.pre = m.pre + 1;
      end
    end else if (m.ph == PH_PAUSE) begin
      if (ld != 0) n.cnt = lv;
      if (st != 0) n.ph = PH_RUN;
    end else begin
      if (st != 0) begin
        n.ph = PH_RUN; n.cnt = lv; n.pre = 0; n.dir = dr; n.term = tv; n.ar = ar;
      end else if (ld != 0) begin
        n.cnt = lv;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 <= mstep(m1, 1, int'(rstn), int'(clear), int'(stop), int'(load), int'(start),
                int'(load_val), int'(term_val), int'(dir), int'(auto_reload));
    m3 <= mstep(m3, 3, int'(rstn), int'(clear), int'(stop), int'(load), int'(start),
                int'(load_val), int'(term_val), int'(dir), int'(auto_reload));
  end

  always @(negedge clk) begin
    if (m1.valid != 0) begin
      chk("mdl1_count", 32'(count1), 32'(m1.cnt));
      chk("mdl1_busy", 32'(busy1), 32'((m1.ph == PH_RUN || m1.ph == PH_PAUSE) ? 1 : 0));
      chk("mdl1_done", 32'(done1), 32'(m1.dn));
    end
    if (m3.valid != 0) begin
      chk("mdl3_count", 32'(count3), 32'(m3.cnt));
      chk("mdl3_busy", 32'(busy3), 32'((m3.ph == PH_RUN || m3.ph == PH_PAUSE) ? 1 : 0));
      chk("mdl3_done", 32'(done3), 32'(m3.dn));
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pin1(input string nm, input int c, input int b, input int d);
    chk({nm, "_count"}, 32'(count1), 32'(c));
    chk({nm, "_busy"}, 32'(busy1), 32'(b));
    chk({nm, "_done"}, 32'(done1), 32'(d));
  endtask

  task automatic pin3(input string nm, input int c, input int b, input int d);
    chk({nm, "_count"}, 32'(count3), 32'(c));
    chk({nm, "_busy"}, 32'(busy3), 32'(b));
    chk({nm, "_done"}, 32'(done3), 32'(d));
  endtask

  int seq3 [19] = '{2, 2, 2, 1, 1, 1, 0, 0, 0, 2, 2, 2, 1, 1, 1, 0, 0, 0, 2};

  initial begin
    rstn = 1'b1; start = 1'b1; stop = 1'b0; clear = 1'b0; load = 1'b1;
    load_val = 4'd9; term_val = 4'd0; dir = 1'b0; auto_reload = 1'b0;

    // Reset overrides start and load.
    cyc(2);
    pin1("rst1", 0, 0, 0);
    pin3("rst3", 0, 0, 0);
    rstn = 1'b0; start = 1'b0; load = 1'b0;

    // One-shot up, load and start together.
    load_val = 4'd3; term_val = 4'd7; dir = 1'b0; auto_reload = 1'b0;
    load = 1'b1; start = 1'b1;
    cyc(1);
    load = 1'b0; start = 1'b0;
    pin1("os_3", 3, 1, 0);
    for (int v = 4; v <= 7; v++) begin
      cyc(1);
      pin1("os_step", v, 1, 0);
    end
    cyc(1);
    pin1("os_term", 7, 0, 1);
    cyc(1);
    pin1("os_hold", 7, 0, 0);

    // Reset while the PRESCALE=3 instance is still in RUN.
    pin3("pre_rst_run", 5, 1, 0);
    rstn = 1'b1;
    cyc(1);
    rstn = 1'b0;
    pin3("midrun_rst", 0, 0, 0);

    // Auto-reload down on the PRESCALE=3 instance.
    load_val = 4'd2; term_val = 4'd0; dir = 1'b1; auto_reload = 1'b1;
    load = 1'b1; start = 1'b1;
    cyc(1);
    load = 1'b0; start = 1'b0;
    pin3("ar_0", seq3[0], 1, 0);
    for (int i = 1; i < 19; i++) begin
      cyc(1);
      pin3("ar_seq", seq3[i], 1, (i == 9 || i == 18) ? 1 : 0);
    end
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    pin3("ar_clear", 0, 0, 0);

    // Stop and resume.
    load_val = 4'd0; term_val = 4'd10; dir = 1'b0; auto_reload = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    pin1("sr_0", 0, 1, 0);
    for (int v = 1; v <= 4; v++) begin
      cyc(1);
      pin1("sr_up", v, 1, 0);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    pin1("sr_paused", 4, 1, 0);
    cyc(2);
    pin1("sr_frozen", 4, 1, 0);
    load_val = 4'd8; load = 1'b1;
    cyc(1);
    load = 1'b0;
    pin1("sr_load", 8, 1, 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    pin1("sr_resume", 8, 1, 0);
    cyc(1);
    pin1("sr_9", 9, 1, 0);
    cyc(1);
    pin1("sr_10", 10, 1, 0);
    cyc(1);
    pin1("sr_done", 10, 0, 1);

    // Wrap-around up from DONE.
    load_val = 4'd14; term_val = 4'd1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    pin1("wr_14", 14, 1, 0);
    cyc(1);
    pin1("wr_15", 15, 1, 0);
    cyc(1);
    pin1("wr_0", 0, 1, 0);
    cyc(1);
    pin1("wr_1", 1, 1, 0);
    cyc(1);
    pin1("wr_done", 1, 0, 1);

    // Relaunch, then clear at 15.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    pin1("cl_14", 14, 1, 0);
    cyc(1);
    pin1("cl_15", 15, 1, 0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    pin1("cl_clear", 0, 0, 0);
    cyc(1);
    pin1("cl_after", 0, 0, 0);

    // Terminal value is latched at launch.
    term_val = 4'd5; dir = 1'b0; auto_reload = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    pin1("cfg_0", 0, 1, 0);
    cyc(1);
    pin1("cfg_1", 1, 1, 0);
    term_val = 4'd2;
    for (int v = 2; v <= 5; v++) begin
      cyc(1);
      pin1("cfg_up", v, 1, 0);
    end
    cyc(1);
    pin1("cfg_done", 5, 0, 1);

    // PRESCALE=1 auto-reload with load_val == term_val pulses done every clock.
    load_val = 4'd6; term_val = 4'd6; auto_reload = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    pin1("cont_launch", 6, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      pin1("cont_done", 6, 1, 1);
    end
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    pin1("cont_clear", 0, 0, 0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
